sobel_stream_engine: RTL and testbench
======================================

Name: sobel_stream_engine

Overview:
Streaming successor to the single-window Sobel controller. It accepts grayscale pixels in raster order over a valid/ready handshake and holds two line buffers plus a 3x3 sliding window, so every input pixel is read exactly once. It emits one Sobel magnitude per interior pixel, either raw-saturated or binarized, selected at run time. It sits between the grayscale converter and the output frame writer.

Parameters:
PIXEL_WIDTH, 8, bits per grayscale and output pixel
IMAGE_WIDTH, 640, pixels per row; legal range is 3 or more
IMAGE_HEIGHT, 480, rows per frame; legal range is 3 or more
DEFAULT_THRESHOLD, 64, reset value of the internal threshold register

Ports:
clk_i  in  1  single clock, rising edge
nreset_i  in  1  asynchronous active-low reset
mode_bin_i  in  1  0 = raw magnitude output, 1 = binarized output
threshold_i  in  PIXEL_WIDTH  threshold value, sampled at frame start
px_valid_i  in  1  input pixel valid
px_data_i  in  PIXEL_WIDTH  input grayscale pixel
px_ready_o  out  1  engine can accept a pixel
sobel_valid_o  out  1  output pixel valid
sobel_data_o  out  PIXEL_WIDTH  output Sobel pixel
sobel_ready_i  in  1  downstream accepts the output pixel
frame_done_o  out  1  one-cycle pulse when the last output of a frame is accepted
busy_o  out  1  a frame is in progress

Behaviour:
- Clock and reset: one clock, clk_i. Reset nreset_i is asynchronous and active-low.
- Reset values:
  - px_ready_o=1, sobel_valid_o=0, sobel_data_o=0, frame_done_o=0, busy_o=0.
  - Row and column counters = 0; window = 0.
  - Threshold register = DEFAULT_THRESHOLD.
  - Line-buffer contents are don't-care.
- Input handshake: a pixel is accepted when px_valid_i and px_ready_o are both 1.
  - px_ready_o = !sobel_valid_o || sobel_ready_i. This gives a single-stage skid-free pipeline.
- Counters: col counts 0..IMAGE_WIDTH-1 and row counts 0..IMAGE_HEIGHT-1, both on accept.
  - col wraps to 0 and row increments.
  - After (IMAGE_HEIGHT-1, IMAGE_WIDTH-1), both wrap to 0 and the next frame starts with no idle cycle.
- Frame start: on accept at (0,0), latch threshold_i and mode_bin_i, and set busy_o.
  - Changing these inputs mid-frame has no effect.
- Line buffers and window, on each accept at column c:
  - top = lb1[c], mid = lb0[c], bot = px_data_i.
  - Then write lb1[c] <= lb0[c] and lb0[c] <= px_data_i.
  - The window shifts left by one column, and {top, mid, bot} enter the right column.
  - The window is cleared when c = 0 is accepted, so no data carries across rows.
- Output condition: an accept at (r,c) with r >= 2 and c >= 2 produces the result for centre (r-1, c-1).
  - The result registers on that same clock edge, so sobel_valid_o rises in the next cycle (latency 1).
  - Outputs per frame = (IMAGE_HEIGHT-2)*(IMAGE_WIDTH-2). Border pixels produce no output.
- Arithmetic, with window pRC (R,C in 0..2) after the shift:
  - Gx = (p02+2p12+p22) - (p00+2p10+p20).
  - Gy = (p20+2p21+p22) - (p00+2p01+p02).
  - Gx and Gy are signed, PIXEL_WIDTH+4 bits.
  - mag = |Gx| + |Gy|, saturated to 2^PIXEL_WIDTH-1.
  - In binarized mode: output = (mag >= threshold) ? 2^PIXEL_WIDTH-1 : 0.
- Output hold: sobel_valid_o stays high, and sobel_data_o stays stable, until sobel_ready_i.
  - A new result may load in the same cycle the old one is accepted.
- Frame end and busy:
  - frame_done_o pulses for 1 cycle on acceptance of the output for centre (IMAGE_HEIGHT-2, IMAGE_WIDTH-2).
  - busy_o clears in that same cycle unless (0,0) of the next frame is accepted simultaneously.
- Simultaneous events: a new-frame accept at (0,0) may coincide with frame_done_o. The done pulse still fires and busy_o stays 1.
- Reset mid-frame: all counters, the window, the output valid and busy are cleared immediately. The next accepted pixel is treated as (0,0).

Test Plan:
1. W=5, H=4, constant 100 image, ready always 1 -> 6 outputs, all 0. frame_done_o pulses once, 1 cycle after the 6th output valid.
2. Columns 0-1 = 0, columns 2-4 = 10, mode_bin=0 -> each output row is 40, 40, 0 (rows 1 and 2).
3. Same image as scenario 2 with mode_bin=1 and threshold 32 -> each output row is 255, 255, 0. Changing threshold_i to 50 mid-frame leaves the outputs unchanged.
4. Columns 0-1 = 0, columns 2-4 = 255 -> |Gx|=1020 saturates, giving outputs 255, 255, 0 per row.
5. sobel_ready_i toggled randomly -> sobel_data_o is stable while stalled and px_ready_o=0 while valid and not ready. The output stream is bit-identical to scenario 2.
6. Reset asserted after 7 pixels accepted, then a full frame sent -> the full set of correct outputs, and no output from the partial frame.

Source files
------------

// File: rtl/sobel_stream_engine.sv
// sobel_stream_engine
//   Streaming 3x3 Sobel edge engine. Pixels arrive in raster order. Two line
//   buffers hold the previous two rows. A 3x3 window slides across each row,
//   so every input pixel is read once. One magnitude is produced per interior
//   pixel, either raw-saturated or binarized against a threshold that is
//   captured at frame start.
//
// Ports
//   clk_i          rising-edge clock
//   nreset_i       asynchronous active-low reset
//   mode_bin_i     0 = raw magnitude, 1 = binarized (latched at frame start)
//   threshold_i    binarize threshold (latched at frame start)
//   px_valid_i     input pixel valid
//   px_data_i      input grayscale pixel
//   px_ready_o     engine can accept a pixel
//   sobel_valid_o  output pixel valid
//   sobel_data_o   output Sobel pixel
//   sobel_ready_i  downstream accepts output pixel
//   frame_done_o   one-cycle pulse after the last output of a frame is taken
//   busy_o         a frame is in progress
module sobel_stream_engine #(
  parameter int PIXEL_WIDTH       = 8,
  parameter int IMAGE_WIDTH       = 640,
  parameter int IMAGE_HEIGHT      = 480,
  parameter int DEFAULT_THRESHOLD = 64
) (
  input  logic                   clk_i,
  input  logic                   nreset_i,
  input  logic                   mode_bin_i,
  input  logic [PIXEL_WIDTH-1:0] threshold_i,
  input  logic                   px_valid_i,
  input  logic [PIXEL_WIDTH-1:0] px_data_i,
  output logic                   px_ready_o,
  output logic                   sobel_valid_o,
  output logic [PIXEL_WIDTH-1:0] sobel_data_o,
  input  logic                   sobel_ready_i,
  output logic                   frame_done_o,
  output logic                   busy_o
);

  localparam int CW = $clog2(IMAGE_WIDTH);
  localparam int RW = $clog2(IMAGE_HEIGHT);
  // 4 * (2^PIXEL_WIDTH - 1) plus a sign bit fits in PIXEL_WIDTH+4 bits
  localparam int GW = PIXEL_WIDTH + 4;
  localparam logic [PIXEL_WIDTH-1:0] PX_MAX = '1;

  logic [CW-1:0]          col_q;
  logic [RW-1:0]          row_q;
  logic                   px_accept;
  logic                   col_first;
  logic                   col_last;
  logic                   row_last;
  logic                   frame_start;
  logic                   out_fire;
  logic                   out_accept;
  logic                   out_last_q;

  logic                   mode_q;
  logic [PIXEL_WIDTH-1:0] thr_q;

  logic [PIXEL_WIDTH-1:0] lb0 [IMAGE_WIDTH];
  logic [PIXEL_WIDTH-1:0] lb1 [IMAGE_WIDTH];

  logic [PIXEL_WIDTH-1:0] win_q [3][3];
  logic [PIXEL_WIDTH-1:0] win_d [3][3];
  logic [PIXEL_WIDTH-1:0] new_col [3];

  logic signed [GW-1:0]   gx;
  logic signed [GW-1:0]   gy;
  logic [GW-1:0]          abs_gx;
  logic [GW-1:0]          abs_gy;
  logic [GW-1:0]          mag_sum;
  logic [PIXEL_WIDTH-1:0] mag_sat;
  logic [PIXEL_WIDTH-1:0] result;

  function automatic logic signed [GW-1:0] ext(input logic [PIXEL_WIDTH-1:0] p);
    return $signed({{(GW-PIXEL_WIDTH){1'b0}}, p});
  endfunction

  assign px_ready_o  = !sobel_valid_o || sobel_ready_i;
  assign px_accept   = px_valid_i && px_ready_o;
  assign col_first   = (col_q == '0);
  assign col_last    = (col_q == CW'(IMAGE_WIDTH - 1));
  assign row_last    = (row_q == RW'(IMAGE_HEIGHT - 1));
  assign frame_start = px_accept && col_first && (row_q == '0);
  assign out_fire    = px_accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign out_accept  = sobel_valid_o && sobel_ready_i;

  // Window after the shift; the left two columns are zeroed at the start of a
  // row so nothing from the previous row leaks in.
  always_comb begin
    new_col[0] = lb1[col_q];
    new_col[1] = lb0[col_q];
    new_col[2] = px_data_i;
    for (int r = 0; r < 3; r++) begin
      win_d[r][0] = col_first ? '0 : win_q[r][1];
      win_d[r][1] = col_first ? '0 : win_q[r][2];
      win_d[r][2] = new_col[r];
    end
  end

  always_comb begin
    gx = (ext(win_d[0][2]) + ext(win_d[1][2]) + ext(win_d[1][2]) + ext(win_d[2][2]))
       - (ext(win_d[0][0]) + ext(win_d[1][0]) + ext(win_d[1][0]) + ext(win_d[2][0]));
    gy = (ext(win_d[2][0]) + ext(win_d[2][1]) + ext(win_d[2][1]) + ext(win_d[2][2]))
       - (ext(win_d[0][0]) + ext(win_d[0][1]) + ext(win_d[0][1]) + ext(win_d[0][2]));
    abs_gx  = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
    abs_gy  = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
    mag_sum = abs_gx + abs_gy;
    mag_sat = (|mag_sum[GW-1:PIXEL_WIDTH]) ? PX_MAX : mag_sum[PIXEL_WIDTH-1:0];
    result  = mode_q ? ((mag_sat >= thr_q) ? PX_MAX : '0) : mag_sat;
  end

  // Line buffer contents need no reset: rows 0 and 1 rewrite them before any
  // output depends on them.
  always_ff @(posedge clk_i) begin
    if (px_accept) begin
      lb1[col_q] <= lb0[col_q];
      lb0[col_q] <= px_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      col_q <= '0;
      row_q <= '0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else if (px_accept) begin
      win_q <= win_d;
      if (col_last) begin
        col_q <= '0;
        row_q <= row_last ? '0 : row_q + RW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      mode_q <= 1'b0;
      thr_q  <= PIXEL_WIDTH'(DEFAULT_THRESHOLD);
    end else if (frame_start) begin
      mode_q <= mode_bin_i;
      thr_q  <= threshold_i;
    end
  end

  // Single output register; a new result may replace one being accepted.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      sobel_valid_o <= 1'b0;
      sobel_data_o  <= '0;
      out_last_q    <= 1'b0;
    end else if (out_fire) begin
      sobel_valid_o <= 1'b1;
      sobel_data_o  <= result;
      out_last_q    <= row_last && col_last;
    end else if (sobel_ready_i) begin
      sobel_valid_o <= 1'b0;
    end
  end

  // A new frame starting on the same edge as the previous frame's final
  // output keeps busy asserted.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      frame_done_o <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      frame_done_o <= out_accept && out_last_q;
      if (frame_start) begin
        busy_o <= 1'b1;
      end else if (out_accept && out_last_q) begin
        busy_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sobel_stream_engine.sv
module tb_sobel_stream_engine;
  localparam int PW = 8;
  localparam int W  = 5;
  localparam int H  = 4;

  logic          clk_i = 1'b0;
  logic          nreset_i;
  logic          mode_bin_i;
  logic [PW-1:0] threshold_i;
  logic          px_valid_i;
  logic [PW-1:0] px_data_i;
  logic          px_ready_o;
  logic          sobel_valid_o;
  logic [PW-1:0] sobel_data_o;
  logic          sobel_ready_i;
  logic          frame_done_o;
  logic          busy_o;

  sobel_stream_engine #(
    .PIXEL_WIDTH(PW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)
  ) dut (
    .clk_i(clk_i), .nreset_i(nreset_i), .mode_bin_i(mode_bin_i),
    .threshold_i(threshold_i), .px_valid_i(px_valid_i), .px_data_i(px_data_i),
    .px_ready_o(px_ready_o), .sobel_valid_o(sobel_valid_o), .sobel_data_o(sobel_data_o),
    .sobel_ready_i(sobel_ready_i), .frame_done_o(frame_done_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int d;
    bit last;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  int   img [H][W];
  exp_t exp_q[$];
  int   got_q[$];
  bit   cmp_en = 1'b0;
  bit   rnd_ready = 1'b0;
  bit   drv_first = 1'b0;
  int   done_cnt = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic abort(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timeout at %0t", name, $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bench aborted");
  endtask

  // kind 0: constant 100; kind 1: cols 0-1 = 0, rest = v
  task automatic set_img(input int kind, input int v);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = (kind == 0) ? 100 : ((c < 2) ? 0 : v);
  endtask

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  // Reference Sobel over the whole stored image, interior centres in raster order.
  task automatic build_expected(input bit mb, input int thr);
    int gx, gy, m;
    exp_t e;
    for (int r = 1; r <= H - 2; r++) begin
      for (int c = 1; c <= W - 2; c++) begin
        gx = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
           - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
        gy = (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1])
           - (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]);
        m = iabs(gx) + iabs(gy);
        if (m > 255) m = 255;
        if (mb) m = (m >= thr) ? 255 : 0;
        e.d = m;
        e.last = (r == H - 2) && (c == W - 2);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic send_pixels(input int count, input int chg_at);
    int n;
    bit acc;
    for (int i = 0; i < count; i++) begin
      px_valid_i = 1'b1;
      px_data_i  = PW'(img[i / W][i % W]);
      drv_first  = (i == 0);
      n = 0;
      acc = 1'b0;
      while (!acc) begin
        @(negedge clk_i);
        if (px_ready_o) acc = 1'b1;
        else n++;
        if (n > 100) abort("px_accept");
      end
      @(posedge clk_i);
      #1;
      if (i == chg_at) threshold_i = 8'd50;
    end
    px_valid_i = 1'b0;
    drv_first  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk_i);
      n++;
    end
    if (exp_q.size() != 0) abort("drain");
    repeat (3) @(posedge clk_i);
    #1;
  endtask

  // Pops one frame (two output rows) from the captured stream and compares to a literal row.
  task automatic check_rows(input string nm, input int a, input int b, input int c);
    int pat [3];
    pat[0] = a; pat[1] = b; pat[2] = c;
    chk({nm, "_count"}, (got_q.size() >= 6) ? 1 : 0, 1);
    for (int i = 0; i < 6; i++) begin
      if (got_q.size() > 0) chk(nm, got_q.pop_front(), pat[i % 3]);
    end
  endtask

  task automatic check_reset_values();
    chk("rst_px_ready", px_ready_o, 1);
    chk("rst_valid", sobel_valid_o, 0);
    chk("rst_data", sobel_data_o, 0);
    chk("rst_done", frame_done_o, 0);
    chk("rst_busy", busy_o, 0);
  endtask

  initial begin
    sobel_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      sobel_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  bit   prev_stall;
  int   prev_data;
  bit   done_exp;
  bit   busy_exp;
  bit   nb;
  exp_t ce;

  always @(negedge clk_i) begin
    if (!nreset_i) begin
      prev_stall = 1'b0;
      done_exp   = 1'b0;
      busy_exp   = 1'b0;
    end else if (cmp_en) begin
      if (prev_stall) begin
        chk("hold_valid", sobel_valid_o, 1);
        chk("hold_data", sobel_data_o, prev_data);
      end
      chk("px_ready", px_ready_o, (!sobel_valid_o || sobel_ready_i) ? 1 : 0);
      chk("frame_done", frame_done_o, done_exp);
      chk("busy", busy_o, busy_exp);
      if (frame_done_o) done_cnt++;
      nb = busy_exp;
      if (px_valid_i && px_ready_o && drv_first) nb = 1'b1;
      done_exp = 1'b0;
      if (sobel_valid_o && sobel_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got %0d expected no output at %0t", sobel_data_o, $time);
        end else begin
          ce = exp_q.pop_front();
          chk("sobel_data", sobel_data_o, ce.d);
          done_exp = ce.last;
          if (ce.last && !(px_valid_i && px_ready_o && drv_first)) nb = 1'b0;
        end
        got_q.push_back(int'(sobel_data_o));
      end
      busy_exp   = nb;
      prev_stall = sobel_valid_o && !sobel_ready_i;
      prev_data  = sobel_data_o;
    end
  end

  initial begin
    nreset_i    = 1'b0;
    mode_bin_i  = 1'b0;
    threshold_i = 8'd32;
    px_valid_i  = 1'b0;
    px_data_i   = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check_reset_values();
    nreset_i = 1'b1;
    cmp_en   = 1'b1;
    @(posedge clk_i);
    #1;

    // constant image -> all zero, one done pulse
    set_img(0, 0);
    build_expected(1'b0, 0);
    send_pixels(W * H, -1);
    drain();
    chk("s1_done_cnt", done_cnt, 1);
    chk("s1_busy_idle", busy_o, 0);
    check_rows("s1_out", 0, 0, 0);

    // step of 10 then step of 255, back to back (new frame meets done pulse)
    set_img(1, 10);
    build_expected(1'b0, 0);
    chk("model_s2_c1", exp_q[0].d, 40);
    chk("model_s2_c3", exp_q[2].d, 0);
    send_pixels(W * H, -1);
    set_img(1, 255);
    build_expected(1'b0, 0);
    chk("model_s4_sat", exp_q[exp_q.size() - 6].d, 255);
    send_pixels(W * H, -1);
    drain();
    chk("s24_done_cnt", done_cnt, 3);
    check_rows("s2_out", 40, 40, 0);
    check_rows("s4_out", 255, 255, 0);

    // binarized, threshold changed mid-frame has no effect
    mode_bin_i  = 1'b1;
    threshold_i = 8'd32;
    set_img(1, 10);
    build_expected(1'b1, 32);
    send_pixels(W * H, 7);
    drain();
    check_rows("s3_out", 255, 255, 0);
    threshold_i = 8'd32;
    mode_bin_i  = 1'b0;

    // random backpressure
    rnd_ready = 1'b1;
    build_expected(1'b0, 0);
    send_pixels(W * H, -1);
    drain();
    rnd_ready = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_rows("s5_out", 40, 40, 0);

    // reset after a partial frame, then a full frame
    send_pixels(7, -1);
    chk("s6_busy_partial", busy_o, 1);
    nreset_i = 1'b0;
    @(negedge clk_i);
    check_reset_values();
    @(posedge clk_i);
    #1;
    nreset_i = 1'b1;
    chk("s6_no_partial_out", got_q.size(), 0);
    build_expected(1'b0, 0);
    send_pixels(W * H, -1);
    drain();
    chk("s6_count", got_q.size(), 6);
    check_rows("s6_out", 40, 40, 0);
    chk("s6_done_cnt", done_cnt, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
